// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream, seen from the reader (master).
interface fifo_stream_reader_if #(
  parameter int MSB = 3,
  parameter int LSB = 0
);

  logic           fifo_read;
  logic           fifo_empty;
  logic [MSB:LSB] fifo_out;
  logic           m_valid;
  logic [MSB:LSB] m_data;
  logic           m_ready;

  modport master (
    output fifo_read,
    output m_valid,
    output m_data,
    input  fifo_empty,
    input  fifo_out,
    input  m_ready
  );

  modport slave (
    input  fifo_read,
    input  m_valid,
    input  m_data,
    output fifo_empty,
    output fifo_out,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry oldest-first skid buffer; data_o is always the oldest word.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int MSB = 3,
  parameter int LSB = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cap_i,
  input  logic [MSB:LSB] din_i,
  input  logic           pop_i,
  output logic [MSB:LSB] data_o,
  output logic           valid_o,
  output logic [1:0]     occ_o
);

  skid_state_t    state_q;
  logic [MSB:LSB] d0_q;
  logic [MSB:LSB] d1_q;
  logic           valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d0_q    <= '0;
      d1_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (cap_i) begin
            d0_q    <= din_i;
            state_q <= ONE;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (cap_i && pop_i) begin
            d0_q <= din_i;
          end else if (cap_i) begin
            d1_q    <= din_i;
            state_q <= TWO;
          end else if (pop_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          // Pop promotes the younger entry; a simultaneous capture refills its slot.
          if (pop_i) begin
            d0_q <= d1_q;
            if (cap_i) d1_q    <= din_i;
            else       state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    occ_o = '0;
    case (state_q)
      EMPTY:   occ_o = 2'd0;
      ONE:     occ_o = 2'd1;
      TWO:     occ_o = 2'd2;
      default: occ_o = 2'd0;
    endcase
  end

  assign data_o  = d0_q;
  assign valid_o = valid_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == TWO && cap_i && !pop_i));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream at one word per clock.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int MSB   = 3,
  parameter int LSB   = 0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     xfer_cnt
);

  logic [1:0]       occ;
  logic             infl_q;
  logic             pop;
  logic [2:0]       pending;
  logic [2:0]       limit;
  logic [CNT_W-1:0] xfer_cnt_q;
  logic [CNT_W-1:0] xfer_cnt_d;

  assign pop = bus.m_valid && bus.m_ready;

  // occ + infl - pop < depth, rearranged to avoid unsigned underflow.
  assign pending       = {1'b0, occ} + {2'b00, infl_q};
  assign limit         = 3'(SKID_DEPTH) + {2'b00, pop};
  assign bus.fifo_read = enable && !bus.fifo_empty && (pending < limit);

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      infl_q     <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      infl_q     <= bus.fifo_read;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

  stream_skid_buf #(
    .MSB (MSB),
    .LSB (LSB)
  ) u_skid (
    .clk     (clk),
    .rst_n   (reset_n),
    .cap_i   (infl_q),
    .din_i   (bus.fifo_out),
    .pop_i   (pop),
    .data_o  (bus.m_data),
    .valid_o (bus.m_valid),
    .occ_o   (occ)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural registered-output FIFO feeding the stream reader.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = '0;
  logic [3:0] xfer_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  fifo_stream_reader_if #(.MSB(3), .LSB(0)) bus ();

  fifo_stream_reader #(
    .MSB   (3),
    .LSB   (0),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read data, shares the reader's reset.
  logic [3:0] mem [32];
  logic [4:0] wp, rp;
  logic [5:0] cnt;

  assign bus.fifo_empty = (cnt == 6'd0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      bus.fifo_out <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 5'd1;
      end
      if (bus.fifo_read && cnt != 6'd0) begin
        bus.fifo_out <= mem[rp];
        rp <= rp + 5'd1;
      end
      cnt <= cnt + {5'd0, wr_en} - {5'd0, (bus.fifo_read && cnt != 6'd0)};
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    bus.m_ready = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [3:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.m_valid); end
    tests_run++;
    if (bus.m_data !== 4'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", bus.m_data); end
    tests_run++;
    if (xfer_cnt !== 4'h0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt); end
    tests_run++;
    if (bus.fifo_read !== 1'b0) begin tests_failed++; $display("FAIL reset_read: got %b expected 0", bus.fifo_read); end
    do_reset();
  endtask

  task automatic test_streaming();
    logic [3:0] e;
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    bus.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) enable = 1'b1;
      #1;
      e = 4'(c - 1);
      tests_run++;
      if (bus.fifo_read !== (c < 4)) begin tests_failed++; $display("FAIL stream_read c%0d: got %b expected %b", c, bus.fifo_read, (c < 4)); end
      tests_run++;
      if (bus.m_valid !== (c >= 2 && c <= 5)) begin tests_failed++; $display("FAIL stream_valid c%0d: got %b expected %b", c, bus.m_valid, (c >= 2 && c <= 5)); end
      if (c >= 2 && c <= 5) begin
        tests_run++;
        if (bus.m_data !== e) begin tests_failed++; $display("FAIL stream_data c%0d: got %h expected %h", c, bus.m_data, e); end
      end
    end
    tests_run++;
    if (xfer_cnt !== 4'd4) begin tests_failed++; $display("FAIL stream_cnt: got %0d expected 4", xfer_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int nreads;
    logic [3:0] e;
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    bus.m_ready = 1'b0;
    nreads = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) enable = 1'b1;
      #1;
      if (bus.fifo_read === 1'b1) nreads++;
      if (c >= 2) begin
        tests_run++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 4'h1) begin
          tests_failed++;
          $display("FAIL bp_hold c%0d: got v=%b d=%h expected v=1 d=1", c, bus.m_valid, bus.m_data);
        end
      end
    end
    tests_run++;
    if (nreads != 2) begin tests_failed++; $display("FAIL bp_reads: got %0d expected 2", nreads); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) bus.m_ready = 1'b1;
      #1;
      e = 4'(c + 1);
      tests_run++;
      if (bus.m_valid !== (c < 4)) begin tests_failed++; $display("FAIL bp_valid c%0d: got %b expected %b", c, bus.m_valid, (c < 4)); end
      if (c < 4) begin
        tests_run++;
        if (bus.m_data !== e) begin tests_failed++; $display("FAIL bp_data c%0d: got %h expected %h", c, bus.m_data, e); end
      end
    end
    tests_run++;
    if (xfer_cnt !== 4'd4) begin tests_failed++; $display("FAIL bp_cnt: got %0d expected 4", xfer_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_empty_boundary();
    do_reset();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      wr_en = (c == 2);
      wr_data = 4'hA;
      #1;
      tests_run++;
      if (bus.fifo_read !== (c == 3)) begin tests_failed++; $display("FAIL empty_read c%0d: got %b expected %b", c, bus.fifo_read, (c == 3)); end
      tests_run++;
      if ((bus.fifo_read && bus.fifo_empty) !== 1'b0) begin tests_failed++; $display("FAIL empty_gate c%0d: got read=1 empty=1 expected no read", c); end
      tests_run++;
      if (bus.m_valid !== (c == 5)) begin tests_failed++; $display("FAIL empty_valid c%0d: got %b expected %b", c, bus.m_valid, (c == 5)); end
      if (c == 5) begin
        tests_run++;
        if (bus.m_data !== 4'hA) begin tests_failed++; $display("FAIL empty_data: got %h expected a", bus.m_data); end
      end
    end
    wr_en = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    push(4'h5);
    push(4'h6);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      enable = (c == 0) || (c >= 6);
      #1;
      tests_run++;
      if (bus.fifo_read !== ((c == 0) || (c == 6))) begin tests_failed++; $display("FAIL en_read c%0d: got %b expected %b", c, bus.fifo_read, ((c == 0) || (c == 6))); end
      tests_run++;
      if (bus.m_valid !== ((c == 2) || (c == 8))) begin tests_failed++; $display("FAIL en_valid c%0d: got %b expected %b", c, bus.m_valid, ((c == 2) || (c == 8))); end
      if (c == 2) begin
        tests_run++;
        if (bus.m_data !== 4'h5) begin tests_failed++; $display("FAIL en_data0: got %h expected 5", bus.m_data); end
      end
      if (c == 8) begin
        tests_run++;
        if (bus.m_data !== 4'h6) begin tests_failed++; $display("FAIL en_data1: got %h expected 6", bus.m_data); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      enable = 1'b1;
      bus.m_ready = (c == 2);
      #1;
    end
    tests_run++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 4'h2 || xfer_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL mr_pre: got v=%b d=%h cnt=%0d expected v=1 d=2 cnt=1", bus.m_valid, bus.m_data, xfer_cnt);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL mr_valid: got %b expected 0", bus.m_valid); end
    tests_run++;
    if (bus.m_data !== 4'h0) begin tests_failed++; $display("FAIL mr_data: got %h expected 0", bus.m_data); end
    tests_run++;
    if (xfer_cnt !== 4'd0) begin tests_failed++; $display("FAIL mr_cnt: got %0d expected 0", xfer_cnt); end
    enable = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    push(4'h7);
    push(4'h8);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) enable = 1'b1;
      #1;
      tests_run++;
      if (bus.m_valid !== (c == 2 || c == 3)) begin tests_failed++; $display("FAIL mr_resume_valid c%0d: got %b expected %b", c, bus.m_valid, (c == 2 || c == 3)); end
      if (c == 2) begin
        tests_run++;
        if (bus.m_data !== 4'h7) begin tests_failed++; $display("FAIL mr_resume_d0: got %h expected 7", bus.m_data); end
      end
      if (c == 3) begin
        tests_run++;
        if (bus.m_data !== 4'h8) begin tests_failed++; $display("FAIL mr_resume_d1: got %h expected 8", bus.m_data); end
      end
    end
    tests_run++;
    if (xfer_cnt !== 4'd2) begin tests_failed++; $display("FAIL mr_resume_cnt: got %0d expected 2", xfer_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_counter_wrap();
    int pops;
    do_reset();
    for (int i = 0; i < 17; i++) push(4'(i));
    bus.m_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      enable = 1'b1;
      #1;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) pops++;
    end
    tests_run++;
    if (pops != 17) begin tests_failed++; $display("FAIL wrap_pops: got %0d expected 17", pops); end
    tests_run++;
    if (xfer_cnt !== 4'd1) begin tests_failed++; $display("FAIL wrap_cnt: got %0d expected 1", xfer_cnt); end
    enable = 1'b0;
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_enable_drop();
    test_mid_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
